// File: rtl/mxv_pkg.sv
// Shared types and constants for the matrix-vector product datapath.
package mxv_pkg;

  typedef logic [7:0]  uint8_t;
  typedef logic [15:0] uint16_t;

  localparam int unsigned DW_DBL      = 16;
  localparam int unsigned MXV_MEM_LAT = 1;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StCapture,
    StResp
  } mxv_feed_state_e;

endpackage

// File: rtl/mxv_idx_counter.sv
// Wrap counter with synchronous clear, enable and a terminal-count flag.
module mxv_idx_counter #(
  parameter int unsigned Max = 4,
  parameter int unsigned W   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last
);

  localparam logic [W-1:0] LastVal = W'(Max - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= last ? '0 : cnt_q + 1'b1;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == LastVal);

endmodule

// File: rtl/mxv_feeder.sv
// Sequences matrix/vector reads into the MAC processor, one row at a time,
// and returns each row result on a valid/ready port.
module mxv_feeder
  import mxv_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned ROWS = 4,
  parameter int unsigned MAW  = $clog2(ROWS * N),
  parameter int unsigned VAW  = $clog2(N),
  parameter int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [MAW-1:0] mat_addr,
  input  uint8_t         mat_data,
  output logic [VAW-1:0] vec_addr,
  input  uint8_t         vec_data,
  output logic           proc_sync_rst,
  output uint8_t         proc_matrix,
  output uint8_t         proc_vector,
  input  uint16_t        proc_result,
  output logic           res_valid,
  input  logic           res_ready,
  output uint16_t        res_data,
  output logic [RW-1:0]  res_row
);

  mxv_feed_state_e state_q, state_d;
  logic            done_q, done_d;
  uint16_t         res_data_q;
  logic [RW-1:0]   res_row_q;

  logic            col_clr, col_en, col_last;
  logic            row_clr, row_en, row_last;
  logic [VAW-1:0]  col;
  logic [RW-1:0]   row;

  logic            issue;
  logic [VAW-1:0]  col_issue;
  logic [MAW-1:0]  row_base;

  mxv_idx_counter #(
    .Max (N),
    .W   (VAW)
  ) u_col_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (col_clr),
    .en   (col_en),
    .cnt  (col),
    .last (col_last)
  );

  mxv_idx_counter #(
    .Max (ROWS),
    .W   (RW)
  ) u_row_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (row_clr),
    .en   (row_en),
    .cnt  (row),
    .last (row_last)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    col_clr = 1'b0;
    col_en  = 1'b0;
    row_clr = 1'b0;
    row_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StClear;
          row_clr = 1'b1;
        end
      end
      StClear: begin
        state_d = StFeed;
        col_clr = 1'b1;
      end
      StFeed: begin
        col_en = 1'b1;
        if (col_last) state_d = StCapture;
      end
      StCapture: state_d = StResp;
      StResp: begin
        if (res_ready) begin
          if (row_last) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StClear;
            row_en  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Addresses lead the data by one cycle: col 0 is issued in CLEAR, col+1 during FEED.
  always_comb begin
    issue     = 1'b0;
    col_issue = '0;
    if (state_q == StClear) begin
      issue = 1'b1;
    end else if (state_q == StFeed && !col_last) begin
      issue     = 1'b1;
      col_issue = col + 1'b1;
    end
  end

  assign row_base = MAW'(32'(row) * N);
  assign mat_addr = issue ? row_base + MAW'(col_issue) : '0;
  assign vec_addr = issue ? col_issue : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      done_q     <= 1'b0;
      res_data_q <= '0;
      res_row_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (state_q == StCapture) begin
        res_data_q <= proc_result;
        res_row_q  <= row;
      end
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign proc_sync_rst = (state_q == StClear);
  assign proc_matrix   = (state_q == StFeed) ? mat_data : '0;
  assign proc_vector   = (state_q == StFeed) ? vec_data : '0;
  assign res_valid     = (state_q == StResp);
  assign res_data      = res_data_q;
  assign res_row       = res_row_q;

endmodule
